alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 32-bit integer ALU for the single-cycle CPU datapath. Executes MIPS R-type operations selected by `funct`.
- Operands come from the register file (`a` = rs value, `b` = rt value); `shamt` comes from the decoder.
- Result goes to the register-file write-back (rd). Sits between the decoder and register write-back.

Parameters:
- WIDTH, 32, datapath width of `a`, `b` and `out`. Shift amounts use the low log2(WIDTH) bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- ALUen  input  1  operation enable; an operation is captured on a rising edge where ALUen=1
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt)
- shamt  input  5  shift amount for constant shifts
- funct  input  6  operation select (MIPS funct field)
- out  output  WIDTH  registered result
- out_valid  output  1  one-cycle pulse: `out` was updated this cycle
- overflow  output  1  registered signed overflow flag for add/sub
- illegal  output  1  registered flag: captured funct unsupported

Behaviour:
- Reset: on a rising edge with rst_n=0, out=0, out_valid=0, overflow=0, illegal=0. Reset has priority over ALUen.
- Latency: inputs are sampled on the rising edge where ALUen=1; `out`, `overflow`, `illegal` and `out_valid`=1 appear after that edge (1-cycle latency).
- When ALUen=0: out, overflow and illegal hold their values; out_valid=0.
- Back-to-back: ALUen high on consecutive edges gives one result per cycle; no stalls, no handshake.
- funct encoding:
  - 0x00 sll: b << shamt
  - 0x02 srl: b >> shamt, logical
  - 0x03 sra: b >>> shamt, arithmetic
  - 0x04 sllv: b << a[4:0]
  - 0x06 srlv: b >> a[4:0], logical
  - 0x07 srav: b >>> a[4:0], arithmetic
  - 0x20 add: a+b, wraps mod 2^32, overflow flag computed
  - 0x21 addu: a+b, overflow=0
  - 0x22 sub: a-b, overflow flag computed
  - 0x23 subu: a-b, overflow=0
  - 0x24 and
  - 0x25 or
  - 0x26 xor
  - 0x27 nor
  - 0x2A slt: signed compare, out = 1 or 0
  - 0x2B sltu: unsigned compare, out = 1 or 0
- Signed overflow:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from a.
  - The wrapped result is still written to `out`; there is no trap.
- Illegal funct: out=0, illegal=1, overflow=0, out_valid=1.
- illegal and overflow are cleared on every subsequent legal operation.
- Shift amount 0 returns b unchanged.
- Variable shifts ignore a[31:5].

Optional Feature:
- Macro ALU_MULT_EN.
- Defined:
  - funct 0x18 (mult): out = low 32 bits of signed a*b.
  - funct 0x19 (multu): out = low 32 bits of unsigned a*b.
  - Both use the same 1-cycle latency; overflow=0.
- Not defined: funct 0x18 and 0x19 are illegal (out=0, illegal=1). No multiplier logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 with ALUen=1, funct=0x20, a=5, b=7 -> out=0, out_valid=0. Release rst_n, one edge -> out=12, out_valid=1 for one cycle.
- Arithmetic and overflow:
  - add a=0x7FFFFFFF, b=1 -> out=0x80000000, overflow=1.
  - addu same operands -> out=0x80000000, overflow=0.
  - sub a=3, b=5 -> out=0xFFFFFFFE, overflow=0.
- Logic and compare with a=0xF0F0F0F0, b=0x0FF00FF0:
  - and -> 0x00F000F0
  - nor -> 0x000F000F
  - slt a=0xFFFFFFFF, b=1 -> 1
  - sltu same operands -> 0
- Shifts with b=0x80000010:
  - sll shamt=4 -> 0x00000100
  - srl shamt=4 -> 0x08000001
  - sra shamt=4 -> 0xF8000001
  - srav a=0x24 (uses 4) -> 0xF8000001
- Enable and hold: result 12 present, then ALUen=0 with changed inputs for 3 cycles -> out stays 12, out_valid=0. Back-to-back add and then or on consecutive edges -> two consecutive valid results.
- Illegal funct 0x3F -> out=0, illegal=1. Next legal op -> illegal=0. funct 0x18 with a=-3, b=4 -> 0xFFFFFFF4 if ALU_MULT_EN is defined, else illegal=1.

Source files
------------

// File: rtl/alu.sv
// Registered 32-bit MIPS R-type ALU with one-cycle latency.
// Optional multiply ops (funct 0x18/0x19) are built only when ALU_MULT_EN is defined.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ALUen,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [5:0]       funct,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overflow,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] sum, diff;
  logic        [SH_W-1:0]  sh_const, sh_var;

  logic [WIDTH-1:0] out_d, out_q;
  logic             ovf_d, ovf_q;
  logic             ill_d, ill_q;
  logic             vld_q;

  assign a_s      = a;
  assign b_s      = b;
  assign sum      = a + b;
  assign diff     = a - b;
  assign sh_const = SH_W'(shamt);
  assign sh_var   = a[SH_W-1:0];

  // Two's-complement overflow: judged from operand and result sign bits only.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (funct)
      6'h00: out_d = b << sh_const;
      6'h02: out_d = b >> sh_const;
      6'h03: out_d = WIDTH'(b_s >>> sh_const);
      6'h04: out_d = b << sh_var;
      6'h06: out_d = b >> sh_var;
      6'h07: out_d = WIDTH'(b_s >>> sh_var);
      6'h20: begin
        out_d = sum;
        ovf_d = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      6'h21: out_d = sum;
      6'h22: begin
        out_d = diff;
        ovf_d = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
      end
      6'h23: out_d = diff;
      6'h24: out_d = a & b;
      6'h25: out_d = a | b;
      6'h26: out_d = a ^ b;
      6'h27: out_d = ~(a | b);
      6'h2A: out_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      6'h2B: out_d = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULT_EN
      // Low half of the product is identical for signed and unsigned operands.
      6'h18: out_d = WIDTH'(a_s * b_s);
      6'h19: out_d = WIDTH'(a * b);
`endif
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= ALUen;
      if (ALUen) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
        ill_q <= ill_d;
      end
    end
  end

  assign out       = out_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops on out_valid.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ALUen;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] out;
  logic        out_valid, overflow, illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t q[$];

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUen(ALUen), .a(a), .b(b), .shamt(shamt),
    .funct(funct), .out(out), .out_valid(out_valid), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; issues one op and returns at the next negedge.
  task automatic op(input string name, input logic [5:0] f, input logic [31:0] av,
                    input logic [31:0] bv, input logic [4:0] sh,
                    input logic [31:0] eo, input logic eovf, input logic eill);
    exp_t e;
    funct = f; a = av; b = bv; shamt = sh; ALUen = 1'b1;
    e.name = name; e.out = eo; e.ovf = eovf; e.ill = eill;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got out=%h with no pending op", out);
        end else begin
          e = q.pop_front();
          chk({e.name, ".out"}, out, e.out);
          chk({e.name, ".ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
          chk({e.name, ".ill"}, {31'b0, illegal}, {31'b0, e.ill});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ALUen = 1'b1; funct = 6'h20; a = 32'd5; b = 32'd7; shamt = 5'd0;
    // Reset dominates ALUen
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst.out", out, 32'h0);
      chk("rst.valid", {31'b0, out_valid}, 32'h0);
      chk("rst.ovf", {31'b0, overflow}, 32'h0);
      chk("rst.ill", {31'b0, illegal}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.name = "first_add"; e.out = 32'd12; e.ovf = 1'b0; e.ill = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    ALUen = 1'b0; a = 32'h1234; b = 32'h5678; funct = 6'h25;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold.out", out, 32'd12);
      chk("hold.valid", {31'b0, out_valid}, 32'h0);
    end
    @(negedge clk);

    op("add_ovf",  6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 1'b0);
    op("addu",     6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b0);
    op("sub",      6'h22, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0);
    op("sub_ovf",  6'h22, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
    op("subu",     6'h23, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    op("and",      6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, 1'b0);
    op("or",       6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0);
    op("xor",      6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 1'b0, 1'b0);
    op("nor",      6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F, 1'b0, 1'b0);
    op("slt",      6'h2A, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0);
    op("sltu",     6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b0);
    op("sll",      6'h00, 32'h0, 32'h80000010, 5'd4, 32'h00000100, 1'b0, 1'b0);
    op("srl",      6'h02, 32'h0, 32'h80000010, 5'd4, 32'h08000001, 1'b0, 1'b0);
    op("sra",      6'h03, 32'h0, 32'h80000010, 5'd4, 32'hF8000001, 1'b0, 1'b0);
    op("sll0",     6'h00, 32'h0, 32'h80000010, 5'd0, 32'h80000010, 1'b0, 1'b0);
    op("sllv",     6'h04, 32'h24, 32'h80000010, 5'd0, 32'h00000100, 1'b0, 1'b0);
    op("srlv",     6'h06, 32'h24, 32'h80000010, 5'd0, 32'h08000001, 1'b0, 1'b0);
    op("srav",     6'h07, 32'h24, 32'h80000010, 5'd0, 32'hF8000001, 1'b0, 1'b0);
    op("add_ovf2", 6'h20, 32'h80000000, 32'h80000000, 5'd0, 32'h0, 1'b1, 1'b0);
    op("illegal",  6'h3F, 32'h5, 32'h7, 5'd0, 32'h0, 1'b0, 1'b1);
    op("clr_ill",  6'h20, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1'b0);
`ifdef ALU_MULT_EN
    op("mult",     6'h18, 32'hFFFFFFFD, 32'd4, 5'd0, 32'hFFFFFFF4, 1'b0, 1'b0);
    op("multu",    6'h19, 32'hFFFFFFFD, 32'd4, 5'd0, 32'hFFFFFFF4, 1'b0, 1'b0);
`else
    op("mult",     6'h18, 32'hFFFFFFFD, 32'd4, 5'd0, 32'h0, 1'b0, 1'b1);
    op("multu",    6'h19, 32'hFFFFFFFD, 32'd4, 5'd0, 32'h0, 1'b0, 1'b1);
`endif
    op("b2b_add",  6'h20, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 1'b0);
    op("b2b_or",   6'h25, 32'h0F, 32'hF0, 5'd0, 32'hFF, 1'b0, 1'b0);
    ALUen = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("idle.valid", {31'b0, out_valid}, 32'h0);
    chk("idle.out", out, 32'hFF);
    chk("pending", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
